alu_sequencer: RTL and testbench

//  Requester-side controller for the alu block: accepts operation commands from the core

---
 rtl/alu_sequencer_if.sv | 29 ++
 rtl/alu_sequencer.sv | 142 ++++++++++++++
 tb/tb_alu_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Bus bundle between the core, the alu_sequencer and the alu.
// The sequencer uses the slave modport; the core/alu environment uses master.
interface alu_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [5:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [5:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [1:0]  rsp_err;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result, rsp_err
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result, rsp_err
  );
endinterface

// File: rtl/alu_sequencer.sv
// Requester-side alu controller: accepts a command, runs a four-phase start/done
// handshake with the alu, traps div-by-zero and illegal opcodes, and times out a hung alu.
module alu_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 7
) (
  input  logic          clk,
  input  logic          reset,
  alu_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_IDLE, RESP} state_t;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_MUL = 6'b000010;
  localparam logic [5:0] OP_DIV = 6'b000011;
  localparam logic [5:0] OP_AND = 6'b001000;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DIV = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;
  localparam logic [1:0] ERR_ILL = 2'b11;

  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT_CYC);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic        cmd_ready_q;
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic [5:0]  alu_op_q;
  logic        alu_start_q;
  logic        rsp_valid_q;
  logic [15:0] rsp_result_q;
  logic [1:0]  rsp_err_q;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  endfunction

  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      cmd_ready_q  <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready_q && bus.cmd_valid) begin
            cmd_ready_q <= 1'b0;
            alu_a_q     <= bus.cmd_a;
            alu_b_q     <= bus.cmd_b;
            alu_op_q    <= bus.cmd_op;
            cnt         <= '0;
            if (!op_legal(bus.cmd_op)) begin
              rsp_result_q <= '0;
              rsp_err_q    <= ERR_ILL;
              rsp_valid_q  <= 1'b1;
              state        <= RESP;
            end else if (bus.cmd_op == OP_DIV && bus.cmd_b == 8'd0) begin
              rsp_result_q <= 16'hFFFF;
              rsp_err_q    <= ERR_DIV;
              rsp_valid_q  <= 1'b1;
              state        <= RESP;
            end else begin
              alu_start_q <= 1'b1;
              state       <= ISSUE;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end

        // Hold the request until done rises; done has priority over a same-cycle timeout.
        ISSUE: begin
          if (bus.alu_done) begin
            rsp_result_q <= bus.alu_result;
            rsp_err_q    <= ERR_OK;
            alu_start_q  <= 1'b0;
            cnt          <= '0;
            state        <= WAIT_IDLE;
          end else if (cnt_nxt == TMO_CNT) begin
            rsp_result_q <= '0;
            rsp_err_q    <= ERR_TMO;
            alu_start_q  <= 1'b0;
            cnt          <= '0;
            state        <= WAIT_IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        WAIT_IDLE: begin
          if (!bus.alu_done) begin
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else if (cnt_nxt == TMO_CNT) begin
            rsp_err_q   <= ERR_TMO;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt_nxt;
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of commands against a behavioural alu,
// plus hand-written sequences for spurious done and mid-operation reset.
module tb_alu_sequencer;

  logic clk;
  logic reset;

  alu_sequencer_if bus();

  alu_sequencer #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural alu controls
  int          cur_delay = 1;
  int          cur_hold  = 0;
  bit          cur_never = 1'b0;
  bit          cur_stuck = 1'b0;
  logic        model_done = 1'b0;
  logic        spur_done  = 1'b0;
  logic [15:0] model_res  = '0;
  int          start_total = 0;

  assign bus.alu_done   = model_done | spur_done;
  assign bus.alu_result = model_res;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [5:0]  op;
    int          delay;
    int          hold;
    bit          never;
    bit          stuck;
    int          rsp_wait;
    logic [15:0] exp_res;
    logic [1:0]  exp_err;
    bit          chk_res;
    int          exp_lat;
    int          exp_starts;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [5:0] op);
    case (op)
      6'b000000: alu_f = {8'h00, a} + {8'h00, b};
      6'b000001: alu_f = {8'h00, a} - {8'h00, b};
      6'b000010: alu_f = 16'(a) * 16'(b);
      6'b000011: alu_f = (b != 8'd0) ? {8'h00, a / b} : 16'hFFFF;
      6'b001000: alu_f = {8'h00, a & b};
      default:   alu_f = 16'h0000;
    endcase
  endfunction

  // Four-phase alu: done rises cur_delay start cycles after start, falls after start drops
  initial begin : alu_model
    int cyc;
    int hold_left;
    cyc = 0;
    hold_left = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_done = 1'b0;
        cyc = 0;
        hold_left = 0;
      end else if (bus.alu_start) begin
        start_total = start_total + 1;
        cyc = cyc + 1;
        if (!cur_never && !model_done && cyc >= cur_delay) begin
          model_done = 1'b1;
          model_res  = alu_f(bus.alu_a, bus.alu_b, bus.alu_op);
          hold_left  = cur_hold;
        end
      end else begin
        cyc = 0;
        if (model_done && !cur_stuck) begin
          if (hold_left > 0) hold_left = hold_left - 1;
          else model_done = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    int snap;
    int w;
    logic [15:0] res0;
    logic [1:0]  err0;
    cur_delay = v.delay;
    cur_hold  = v.hold;
    cur_never = v.never;
    cur_stuck = v.stuck;
    bus.cmd_a = v.a;
    bus.cmd_b = v.b;
    bus.cmd_op = v.op;
    bus.cmd_valid = 1'b1;
    w = 0;
    while (!bus.cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_accept"}, 32'(bus.cmd_ready), 32'd1);
    if (!bus.cmd_ready) begin
      bus.cmd_valid = 1'b0;
      return;
    end
    snap = start_total;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    if (!bus.rsp_valid) return;
    chk({nm, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    if (v.chk_res) chk({nm, "_result"}, 32'(bus.rsp_result), 32'(v.exp_res));
    chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({nm, "_start_cycles"}, 32'(start_total - snap), 32'(v.exp_starts));
    chk({nm, "_operands"}, 32'({bus.alu_a, bus.alu_b, bus.alu_op}), 32'({v.a, v.b, v.op}));
    chk({nm, "_start_low"}, 32'(bus.alu_start), 32'd0);
    res0 = bus.rsp_result;
    err0 = bus.rsp_err;
    for (int k = 0; k < v.rsp_wait; k++) begin
      @(negedge clk);
      chk({nm, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({nm, "_hold_result"}, 32'({bus.rsp_result, bus.rsp_err}), 32'({res0, err0}));
      chk({nm, "_hold_cmd_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({nm, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_cmd_ready_late"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk({nm, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
    if (v.stuck) begin
      cur_stuck = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t rv;
    //          a       b      op         dly hold nev stk wait  res       err   chk lat st
    vecs[0]  = '{8'd15,  8'd10, 6'b000000, 3, 0, 0, 0, 0, 16'd25,    2'b00, 1, 5,  3};
    vecs[1]  = '{8'd4,   8'd3,  6'b000010, 2, 0, 0, 0, 5, 16'd12,    2'b00, 1, 4,  2};
    vecs[2]  = '{8'd16,  8'd0,  6'b000011, 1, 0, 0, 0, 0, 16'hFFFF,  2'b01, 1, 1,  0};
    vecs[3]  = '{8'd9,   8'd2,  6'b000101, 1, 0, 0, 0, 0, 16'd0,     2'b11, 1, 1,  0};
    vecs[4]  = '{8'd20,  8'd5,  6'b000001, 1, 0, 0, 0, 0, 16'd15,    2'b00, 1, 3,  1};
    vecs[5]  = '{8'd7,   8'd9,  6'b000000, 1, 0, 1, 0, 0, 16'd0,     2'b10, 1, 66, 64};
    vecs[6]  = '{8'd200, 8'd7,  6'b000011, 4, 0, 0, 0, 0, 16'd28,    2'b00, 1, 6,  4};
    vecs[7]  = '{8'd255, 8'd255,6'b000000, 2, 2, 0, 0, 0, 16'd510,   2'b00, 1, 6,  2};
    vecs[8]  = '{8'hF0,  8'h3C, 6'b001000, 1, 0, 0, 1, 0, 16'd0,     2'b10, 0, 66, 1};
    vecs[9]  = '{8'd255, 8'd255,6'b000010, 1, 0, 0, 0, 0, 16'hFE01,  2'b00, 1, 3,  1};
    vecs[10] = '{8'd1,   8'd1,  6'b111111, 1, 0, 0, 0, 0, 16'd0,     2'b11, 1, 1,  0};
    vecs[11] = '{8'd0,   8'd0,  6'b000011, 1, 0, 0, 0, 0, 16'hFFFF,  2'b01, 1, 1,  0};
    vecs[12] = '{8'd3,   8'd4,  6'b001001, 1, 0, 0, 0, 0, 16'd0,     2'b11, 1, 1,  0};
    vecs[13] = '{8'd5,   8'd20, 6'b000001, 1, 0, 0, 0, 0, 16'hFFF1,  2'b00, 1, 3,  1};

    reset = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a = '0;
    bus.cmd_b = '0;
    bus.cmd_op = '0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("reset_alu_regs", 32'({bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_start}), 32'd0);
    chk("reset_rsp", 32'({bus.rsp_valid, bus.rsp_result, bus.rsp_err}), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // done high while idle must not produce a response or start
    spur_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("spur_idle", 32'({bus.rsp_valid, bus.alu_start, bus.cmd_ready}), 32'b001);
    end
    spur_done = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset while the alu request is outstanding
    cur_never = 1'b1;
    cur_stuck = 1'b0;
    bus.cmd_a = 8'd16;
    bus.cmd_b = 8'd4;
    bus.cmd_op = 6'b000011;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_start_before", 32'(bus.alu_start), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_start_async", 32'(bus.alu_start), 32'd0);
    chk("midrst_outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.alu_a}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cur_never = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    rv = '{8'd170, 8'd204, 6'b001000, 2, 0, 0, 0, 0, 16'd136, 2'b00, 1, 4, 2};
    run_vec(rv, "after_rst_and");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
